// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with load/branch/call/ret/inc and a LIFO return-address stack
module pc_call_stack #(
    parameter int WIDTH = 16,
    parameter int STACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [WIDTH-1:0]               in,
    input  logic [WIDTH-1:0]               offset,
    input  logic                           load,
    input  logic                           branch,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           inc,
    output logic [WIDTH-1:0]               out,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           stack_full,
    output logic                           stack_empty,
    output logic                           wrap,
    output logic                           ovf_err,
    output logic                           unf_err
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [WIDTH-1:0] pc_next, inc_val;
    logic [DW-1:0]    depth_next;
    logic [AW-1:0]    top;
    logic             push, wrap_next, ovf_next, unf_next;

    assign stack_full  = depth == DW'(STACK_DEPTH);
    assign stack_empty = depth == '0;
    assign inc_val     = out + 1'b1;
    assign top         = AW'(depth - DW'(1));

    // one prioritized operation per edge: load > call > ret > branch > inc > hold
    always_comb begin
        pc_next    = out;
        depth_next = depth;
        push       = 1'b0;
        wrap_next  = 1'b0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (load) begin
            pc_next = in;
        end else if (call) begin
            ovf_next   = stack_full;
            push       = !stack_full;
            wrap_next  = !stack_full && inc_val == '0;
            pc_next    = stack_full ? out : in;
            depth_next = stack_full ? depth : depth + DW'(1);
        end else if (ret) begin
            unf_next   = stack_empty;
            pc_next    = stack_empty ? out : mem[top];
            depth_next = stack_empty ? depth : depth - DW'(1);
        end else if (branch) begin
            pc_next = out + offset;
        end else if (inc) begin
            pc_next   = inc_val;
            wrap_next = inc_val == '0;
        end
    end

    // PC, stack pointer and single-cycle event pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out     <= RESET_VECTOR;
            depth   <= '0;
            wrap    <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            out     <= pc_next;
            depth   <= depth_next;
            wrap    <= wrap_next;
            ovf_err <= ovf_next;
            unf_err <= unf_next;
        end
    end

    // return-address storage; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (push) mem[depth[AW-1:0]] <= inc_val;
    end
endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: scoreboard-driven directed test of pc_call_stack
module tb_pc_call_stack;
    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  dep;
        logic        full, empty, wrap, ovf, unf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = '0, offset = '0;
    logic        load = 0, branch = 0, call = 0, ret = 0, inc = 0;
    logic [15:0] out;
    logic [3:0]  depth;
    logic        stack_full, stack_empty, wrap, ovf_err, unf_err;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [15:0] m_pc = '0;
    logic [15:0] m_stk[$];

    pc_call_stack #(.WIDTH(16), .STACK_DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
        .clock(clock), .reset_n(reset_n), .in(in), .offset(offset),
        .load(load), .branch(branch), .call(call), .ret(ret), .inc(inc),
        .out(out), .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
        .wrap(wrap), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clock = ~clock;

    task automatic want(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic ld, cl, rt, br, ic,
                        input logic [15:0] a, input logic [15:0] off);
        exp_t e;
        e = '0;
        if (ld) m_pc = a;
        else if (cl) begin
            if (m_stk.size() == 8) e.ovf = 1'b1;
            else begin
                m_stk.push_back(m_pc + 16'd1);
                e.wrap = (m_pc == 16'hFFFF);
                m_pc = a;
            end
        end else if (rt) begin
            if (m_stk.size() == 0) e.unf = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (br) m_pc = m_pc + off;
        else if (ic) begin
            e.wrap = (m_pc == 16'hFFFF);
            m_pc = m_pc + 16'd1;
        end
        e.pc = m_pc;
        e.dep = 4'(m_stk.size());
        e.full = (m_stk.size() == 8);
        e.empty = (m_stk.size() == 0);
        sb.push_back(e);
        {load, call, ret, branch, inc} = {ld, cl, rt, br, ic};
        in = a;
        offset = off;
        @(posedge clock);
        #1;
        {load, call, ret, branch, inc} = '0;
        e = sb.pop_front();
        want({tag, ".out"}, out, e.pc);
        want({tag, ".depth"}, 16'(depth), 16'(e.dep));
        want({tag, ".flags"}, 16'({stack_full, stack_empty, wrap, ovf_err, unf_err}),
             16'({e.full, e.empty, e.wrap, e.ovf, e.unf}));
    endtask

    initial begin
        #12;
        want("rst.out", out, 16'h0000);
        want("rst.flags", 16'({depth, stack_full, stack_empty, wrap, ovf_err, unf_err}), 16'b0000_0_1_0_0_0);
        reset_n = 1'b1;

        step("t1.load", 1, 0, 0, 0, 0, 16'h0123, 0);
        #3 reset_n = 1'b0;
        #1;
        m_pc = 16'h0000;
        m_stk.delete();
        want("t1.async_out", out, 16'h0000);
        want("t1.async_depth", 16'(depth), 16'h0000);
        want("t1.async_empty", 16'(stack_empty), 16'h0001);
        #2 reset_n = 1'b1;

        step("t2.load", 1, 0, 0, 0, 0, 16'hFFFE, 0);
        step("t2.inc1", 0, 0, 0, 0, 1, 0, 0);
        want("t2.pc_ffff", out, 16'hFFFF);
        step("t2.inc2", 0, 0, 0, 0, 1, 0, 0);
        want("t2.wrap_hi", 16'(wrap), 16'h0001);
        step("t2.hold", 0, 0, 0, 0, 0, 0, 0);
        want("t2.wrap_lo", 16'(wrap), 16'h0000);

        step("t3.load", 1, 0, 0, 0, 0, 16'h0100, 0);
        step("t3.call", 0, 1, 0, 0, 0, 16'h2000, 0);
        want("t3.call_pc", out, 16'h2000);
        step("t3.ret", 0, 0, 1, 0, 0, 0, 0);
        want("t3.ret_pc", out, 16'h0101);

        step("t4.load", 1, 0, 0, 0, 0, 16'h1000, 0);
        for (int i = 0; i < 8; i++) step("t4.call", 0, 1, 0, 0, 0, 16'h3000 + 16'(i * 16), 0);
        step("t4.ovf", 0, 1, 0, 0, 0, 16'h7777, 0);
        want("t4.ovf_pc", out, 16'h3070);
        want("t4.ovf_full", 16'({ovf_err, stack_full, depth}), 16'b1_1_1000);
        step("t4.ovf_clr", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("t4.ret", 0, 0, 1, 0, 0, 0, 0);
        want("t4.last_ret", out, 16'h1001);

        step("t5.load", 1, 0, 0, 0, 0, 16'h0040, 0);
        step("t5.unf", 0, 0, 1, 0, 0, 0, 0);
        want("t5.unf", 16'({unf_err, depth}), 16'b1_0000);
        step("t5.unf_clr", 0, 0, 0, 0, 0, 0, 0);

        step("t6.load", 1, 0, 0, 0, 0, 16'h0010, 0);
        step("t6.branch", 0, 0, 0, 1, 0, 0, 16'hFFF0);
        want("t6.branch_pc", out, 16'h0000);
        step("t6.prio", 1, 1, 0, 0, 1, 16'h0500, 0);
        want("t6.prio_pc", out, 16'h0500);

        step("t7.load", 1, 0, 0, 0, 0, 16'hFFFF, 0);
        step("t7.call_wrap", 0, 1, 0, 0, 0, 16'h0200, 0);
        step("t7.prio_cr", 0, 1, 1, 1, 1, 16'h0300, 16'h0005);
        step("t7.prio_rb", 0, 0, 1, 1, 1, 0, 16'h0005);
        step("t7.ret_wrap", 0, 0, 1, 0, 1, 0, 0);
        want("t7.ret_pc", out, 16'h0000);
        step("t7.branch_inc", 0, 0, 0, 1, 1, 0, 16'h0005);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
